// File: rtl/rvn_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package rvn_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer ring: entries are allocated on request acceptance, filled in
// order by responses, and popped by decode. Flush frees every entry at once.
module fetch_fifo
    import rvn_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic            o_full,
    output logic            o_head_filled,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr,
    output logic [AW:0]     o_unfilled
);

    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW-1:0]   r_fill;
    logic [AW:0]     r_count;
    logic [AW:0]     r_unfilled;
    logic [DEPTH-1:0] r_filled;
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];

    logic             w_alloc;
    logic             w_fill;
    logic             w_pop;
    logic [DEPTH-1:0] w_filled_next;

    assign w_alloc = i_alloc && !i_flush;
    assign w_fill  = i_fill  && !i_flush;
    assign w_pop   = i_pop   && !i_flush;

    // Responses arrive in order, so filled entries always sit between head and r_fill.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
        assign w_filled_next[gi] = (w_alloc && r_tail == AW'(gi)) ? 1'b0 :
                                   (w_fill  && r_fill == AW'(gi)) ? 1'b1 :
                                   (w_pop   && r_head == AW'(gi)) ? 1'b0 :
                                   r_filled[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
        end else if (i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
        end else begin
            if (w_alloc) r_tail <= r_tail + AW'(1);
            if (w_fill)  r_fill <= r_fill + AW'(1);
            if (w_pop)   r_head <= r_head + AW'(1);
            r_count    <= r_count + (AW+1)'(w_alloc) - (AW+1)'(w_pop);
            r_unfilled <= r_unfilled + (AW+1)'(w_alloc) - (AW+1)'(w_fill);
            r_filled   <= w_filled_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) r_pc[r_tail]    <= i_alloc_pc;
        if (w_fill)  r_instr[r_fill] <= i_fill_data;
    end

    assign o_full        = (r_count == (AW+1)'(DEPTH));
    assign o_head_filled = r_filled[r_head];
    assign o_head_pc     = r_pc[r_head];
    assign o_head_instr  = r_instr[r_head];
    assign o_unfilled    = r_unfilled;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, in-order imem requests, stale-response
// dropping on redirect. Optional misaligned-target trap: RVN_FETCH_MISALIGN_EN.
module fetch_unit
    import rvn_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misaligned
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int DROP_W = 8;

    fetch_state_e      r_state;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_full;
    logic              w_head_filled;
    logic [XLEN-1:0]   w_head_pc;
    logic [XLEN-1:0]   w_head_instr;
    logic [AW:0]       w_unfilled;
    logic              w_run;
    logic              w_pop;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_fill;
    logic [XLEN-1:0]   w_redir_pc;
    logic [DROP_W-1:0] w_drop_redirect;

    assign w_run = (r_state == ST_RUN);
    assign w_pop = w_run && w_head_filled && if_ready;

    // A full buffer still accepts a request when decode frees the head this cycle,
    // which keeps throughput at one instruction per cycle.
    assign w_req_valid = rst_n && w_run && (!w_full || w_pop) && !redirect_valid;
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_fill      = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

    // Every unfilled entry becomes a stale in-flight response; one landing now is already consumed.
    assign w_drop_redirect = r_drop_cnt + DROP_W'(w_unfilled) - DROP_W'(imem_rsp_valid);

`ifdef RVN_FETCH_MISALIGN_EN
    logic [XLEN-1:0] r_trap_pc;
    logic            w_misaligned;
    logic            w_trap;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc   = redirect_pc;
    assign w_trap       = (r_state == ST_TRAP);
`else
    assign w_redir_pc   = redirect_pc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
`ifdef RVN_FETCH_MISALIGN_EN
            r_trap_pc  <= '0;
`endif
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_drop_cnt <= w_drop_redirect;
`ifdef RVN_FETCH_MISALIGN_EN
            r_state    <= w_misaligned ? ST_TRAP : ST_RUN;
            r_trap_pc  <= redirect_pc;
`else
            r_state    <= ST_RUN;
`endif
        end else begin
            if (imem_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - DROP_W'(1);
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
`ifdef RVN_FETCH_MISALIGN_EN
            if (r_state == ST_TRAP && if_ready) r_state <= ST_HALT;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_alloc       (w_req_fire),
        .i_alloc_pc    (r_fetch_pc),
        .i_fill        (w_fill),
        .i_fill_data   (imem_rsp_data),
        .i_pop         (w_pop),
        .i_flush       (redirect_valid),
        .o_full        (w_full),
        .o_head_filled (w_head_filled),
        .o_head_pc     (w_head_pc),
        .o_head_instr  (w_head_instr),
        .o_unfilled    (w_unfilled)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

`ifdef RVN_FETCH_MISALIGN_EN
    assign if_valid      = w_trap || w_head_filled;
    assign if_pc         = w_trap ? r_trap_pc : (w_head_filled ? w_head_pc : '0);
    assign if_instr      = w_trap ? INSTR_NOP : (w_head_filled ? w_head_instr : '0);
    assign if_misaligned = w_trap;
`else
    assign if_valid      = w_head_filled;
    assign if_pc         = w_head_filled ? w_head_pc : '0;
    assign if_instr      = w_head_filled ? w_head_instr : '0;
    assign if_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/backpressure plus
// hand sequences for redirect, stall, wrap and misaligned-target corner cases.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 1;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    // Memory word returned for an address: addr ^ 0x1300_0000.
    localparam logic [31:0] MAGIC = 32'h1300_0000;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic ifr, input logic mrdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = ifr;
        imem_req_ready = mrdy;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = q_addr[0] ^ MAGIC;
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic adv();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        if (acc) begin
            q_addr.push_back(a);
            q_due.push_back(cyc + lat);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q_addr.delete();
        q_due.delete();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        adv();
        rst_n = 1'b1;
    endtask

    task automatic chk_req(input string tag, input logic rv, input logic [31:0] addr);
        chk({tag, " req_valid"}, {31'h0, imem_req_valid}, {31'h0, rv});
        if (rv) chk({tag, " req_addr"}, imem_req_addr, addr);
    endtask

    task automatic chk_if(input string tag, input logic iv, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, iv});
        if (iv) begin
            chk({tag, " if_pc"}, if_pc, pc);
            chk({tag, " if_instr"}, if_instr, ins);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Streaming at latency 1, reset mid-run, then decode stalled for five cycles.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h1300_0000};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h1300_0004};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h1300_0008};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0, 32'h1300_0000};
        vt[10] = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0, 32'h1300_0000};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0, 32'h1300_0000};
        vt[12] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h1300_0000};
        vt[13] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h1300_0004};
        vt[14] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h1300_0008};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h1300_000C};

        @(negedge clk);
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            if (vt[i].rst) begin
                rst_n = 1'b0;
                q_addr.delete();
                q_due.delete();
            end else begin
                rst_n = 1'b1;
            end
            drive(1'b0, 32'h0, vt[i].ifr, 1'b1);
            chk($sformatf("v%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, vt[i].exp_rv});
            chk($sformatf("v%0d req_addr", i), imem_req_addr, vt[i].exp_addr);
            chk($sformatf("v%0d if_valid", i), {31'h0, if_valid}, {31'h0, vt[i].exp_iv});
            chk($sformatf("v%0d if_pc", i), if_pc, vt[i].exp_pc);
            chk($sformatf("v%0d if_instr", i), if_instr, vt[i].exp_instr);
            if (vt[i].rst) chk($sformatf("v%0d if_misaligned", i), {31'h0, if_misaligned}, 32'h0);
            adv();
        end

        // Latency 3, two requests in flight, redirect to 0x100.
        lat = 3;
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("c0", 1'b1, 32'h0);   adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("c1", 1'b1, 32'h4);   adv();
        drive(1'b1, 32'h100, 1'b1, 1'b1); chk_req("c2", 1'b0, 32'h0);   chk_if("c2", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("c3", 1'b1, 32'h100); chk_if("c3", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("c4", 1'b1, 32'h104); chk_if("c4", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("c5", 1'b0, 32'h0);   chk_if("c5", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("c6", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("c7", 1'b1, 32'h100, 32'h1300_0100); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("c8", 1'b1, 32'h104, 32'h1300_0104); adv();

        // Redirect coinciding with a response and a decode handshake.
        lat = 1;
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   adv();
        drive(1'b1, 32'h200, 1'b1, 1'b1); chk_if("d2", 1'b1, 32'h0, 32'h1300_0000); chk_req("d2", 1'b0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("d3", 1'b1, 32'h200); chk_if("d3", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("d4", 1'b1, 32'h204); chk_if("d4", 1'b0, 0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("d5", 1'b1, 32'h200, 32'h1300_0200); adv();

        // Memory not ready for three cycles, then fetch across the 32-bit wrap.
        do_reset();
        drive(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0); chk_req("e0", 1'b0, 0); adv();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk_req($sformatf("e%0d", k), 1'b1, 32'hFFFF_FFF8);
            adv();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("e4", 1'b1, 32'hFFFF_FFF8); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("e5", 1'b1, 32'hFFFF_FFFC); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("e6", 1'b1, 32'h0);
        chk_if("e6", 1'b1, 32'hFFFF_FFF8, 32'hECFF_FFF8); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("e7", 1'b1, 32'h4);
        chk_if("e7", 1'b1, 32'hFFFF_FFFC, 32'hECFF_FFFC); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("e8", 1'b1, 32'h0, 32'h1300_0000); adv();

        // Redirect to a misaligned target.
        do_reset();
        drive(1'b1, 32'h102, 1'b0, 1'b1); chk_req("f0", 1'b0, 0); adv();
`ifdef RVN_FETCH_MISALIGN_EN
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            chk_req($sformatf("f%0d", k), 1'b0, 0);
            chk_if($sformatf("f%0d", k), 1'b1, 32'h102, 32'h0000_0013);
            chk($sformatf("f%0d misaligned", k), {31'h0, if_misaligned}, 32'h1);
            adv();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("f3", 1'b1, 32'h102, 32'h0000_0013);
        chk("f3 misaligned", {31'h0, if_misaligned}, 32'h1); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("f4", 1'b0, 0); chk_if("f4", 1'b0, 0, 0);
        chk("f4 misaligned", {31'h0, if_misaligned}, 32'h0); adv();
        drive(1'b1, 32'h200, 1'b1, 1'b1); chk_req("f5", 1'b0, 0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("f6", 1'b1, 32'h200);
        chk("f6 misaligned", {31'h0, if_misaligned}, 32'h0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("f7", 1'b1, 32'h204); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("f8", 1'b1, 32'h200, 32'h1300_0200); adv();
`else
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("f1", 1'b1, 32'h100); chk_if("f1", 1'b0, 0, 0);
        chk("f1 misaligned", {31'h0, if_misaligned}, 32'h0); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_req("f2", 1'b1, 32'h104); adv();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   chk_if("f3", 1'b1, 32'h100, 32'h1300_0100);
        chk("f3 misaligned", {31'h0, if_misaligned}, 32'h0); adv();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
